// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register write arbiter and related bus arbiters.
package reg_arb_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StAck  = 2'd2
  } arb_state_e;

  // Index width for n items; never less than one bit so a 1-bit grant id still exists.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  int unsigned cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(rr_ptr) + k) % N;
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one client write at a time into a shared load-enable register,
// with read-back verification of each write.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = DATA_W,
  localparam int unsigned IW = clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        reg_in,
  output logic                    reg_load,
  input  logic [WIDTH-1:0]        reg_out,
  output logic                    busy,
  output logic [IW-1:0]           grant_id,
  output logic                    wr_err,
  input  logic                    err_clr
);

  arb_state_e state_q, state_d;

  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]    grant_id_q, grant_id_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] reg_in_q, reg_in_d;
  logic             reg_load_q, reg_load_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             wr_err_q, wr_err_d;

  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic             take;

  rr_pick #(
    .N(NREQ)
  ) u_pick (
    .req   (req),
    .rr_ptr(rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign take = (state_q == StIdle) && pick_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_found) state_d = StLoad;
      StLoad:  state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output flops are loaded from next-state so every output is registered yet cycle-aligned.
  always_comb begin
    data_d     = data_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    reg_in_d   = reg_in_q;
    wr_err_d   = wr_err_q;
    ack_d      = '0;
    if (take) begin
      data_d     = wdata[32'(pick_idx) * WIDTH +: WIDTH];
      grant_id_d = pick_idx;
      reg_in_d   = data_d;
    end
    reg_load_d = (state_d == StLoad);
    busy_d     = (state_d != StIdle);
    if (state_d == StAck) ack_d[grant_id_q] = 1'b1;
    if (state_q == StAck) begin
      rr_ptr_d = (32'(grant_id_q) == NREQ - 1) ? '0 : grant_id_q + 1'b1;
    end
    if (err_clr) begin
      wr_err_d = 1'b0;
    end else if (state_q == StAck && reg_out != data_q) begin
      wr_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      reg_in_q   <= '0;
      reg_load_q <= 1'b0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      data_q     <= data_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      reg_in_q   <= reg_in_d;
      reg_load_q <= reg_load_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign ack      = ack_q;
  assign reg_in   = reg_in_q;
  assign reg_load = reg_load_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;
  assign wr_err   = wr_err_q;

endmodule
